// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle sequencer: per-target wait states, /DTACK, autovector /VPA and
// watchdog /BERR. Strobes are registered and decoded from the next state.
module bus_cycle_ctrl #(
    parameter int RAM_WS  = 0,
    parameter int ROM_WS  = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic as,
    input  logic uds,
    input  logic lds,
    input  logic iack,
    input  logic ram_sel,
    input  logic rom_sel,
    input  logic duart_sel,
    input  logic duart_dtack,
    output logic dtack,
    output logic vpa,
    output logic berr,
    output logic busy
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_AVEC, S_BERR} state_t;
    typedef enum logic [1:0] {T_NONE, T_RAM, T_ROM, T_DUART} tgt_t;

    localparam logic [CNT_W-1:0] RAM_WS_C = CNT_W'(RAM_WS);
    localparam logic [CNT_W-1:0] ROM_WS_C = CNT_W'(ROM_WS);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_nxt;
    tgt_t             tgt, tgt_nxt;
    logic [CNT_W-1:0] ws_cnt, ws_nxt;
    logic [CNT_W-1:0] tmo_cnt, tmo_nxt;
    logic             ack;

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        ws_nxt    = ws_cnt;
        tmo_nxt   = tmo_cnt;
        ack       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!as && (!uds || !lds || iack)) begin
                    tmo_nxt = '0;
                    if (iack) begin
                        state_nxt = S_AVEC;
                    end else if (duart_sel) begin
                        tgt_nxt   = T_DUART;
                        state_nxt = duart_dtack ? S_WAIT : S_ACK;
                    end else if (rom_sel) begin
                        tgt_nxt   = T_ROM;
                        ws_nxt    = ROM_WS_C;
                        state_nxt = (ROM_WS == 0) ? S_ACK : S_WAIT;
                    end else if (ram_sel) begin
                        tgt_nxt   = T_RAM;
                        ws_nxt    = RAM_WS_C;
                        state_nxt = (RAM_WS == 0) ? S_ACK : S_WAIT;
                    end else begin
                        tgt_nxt   = T_NONE;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A withdrawn /AS outranks both acknowledge and timeout.
                if (as) begin
                    state_nxt = S_IDLE;
                end else begin
                    ack = ((tgt == T_DUART) && !duart_dtack) ||
                          (((tgt == T_RAM) || (tgt == T_ROM)) && (ws_cnt <= CNT_ONE));
                    ws_nxt  = (ws_cnt == '0) ? '0 : ws_cnt - CNT_ONE;
                    tmo_nxt = (tmo_cnt == CNT_MAX) ? CNT_MAX : tmo_cnt + CNT_ONE;
                    if (ack)
                        state_nxt = S_ACK;
                    else if (tmo_cnt == TMO_LAST)
                        state_nxt = S_BERR;
                end
            end
            S_ACK, S_AVEC, S_BERR: begin
                if (as)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            tgt     <= T_NONE;
            ws_cnt  <= '0;
            tmo_cnt <= '0;
            dtack   <= 1'b1;
            vpa     <= 1'b1;
            berr    <= 1'b1;
        end else begin
            state   <= state_nxt;
            tgt     <= tgt_nxt;
            ws_cnt  <= ws_nxt;
            tmo_cnt <= tmo_nxt;
            dtack   <= (state_nxt != S_ACK);
            vpa     <= (state_nxt != S_AVEC);
            berr    <= (state_nxt != S_BERR);
        end
    end

    assign busy = (state != S_IDLE);

endmodule
